// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for the E stage: owns HI/LO, serves mfhi/mflo/mthi/mtlo, raises md_stall.
// Optional build macro MDU_DIVZERO_GUARD_EN: div/divu by zero never starts the unit.
module mdu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  E_MDUOp,
   input  logic [31:0] E_A,
   input  logic [31:0] E_B,
   input  logic        D_is_md,
   output logic        start,
   output logic        busy,
   output logic        md_stall,
   output logic [31:0] E_MDUOut,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = ($clog2(MAX_CYC) > 4) ? $clog2(MAX_CYC) : 4;
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t             state_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic [31:0]        hi_reg, lo_reg, pend_hi_reg, pend_lo_reg;

   logic        is_mult, is_div, is_signed, div_zero, start_ok;
   logic [63:0] mul_a, mul_b, product;
   logic        neg_a, neg_b;
   logic [31:0] mag_a, mag_b, uquo, urem, quo, rem;
   logic [31:0] res_hi, res_lo;

   assign is_mult   = (E_MDUOp == 4'd1) || (E_MDUOp == 4'd2);
   assign is_div    = (E_MDUOp == 4'd3) || (E_MDUOp == 4'd4);
   assign is_signed = (E_MDUOp == 4'd1) || (E_MDUOp == 4'd3);
   assign div_zero  = (E_B == 32'd0);

`ifdef MDU_DIVZERO_GUARD_EN
   assign start_ok = is_mult | (is_div & ~div_zero);
`else
   assign start_ok = is_mult | is_div;
`endif

   assign start    = (state_reg == S_IDLE) && start_ok;
   assign busy     = (state_reg == S_BUSY);
   assign md_stall = D_is_md & (start | busy);
   assign HI       = hi_reg;
   assign LO       = lo_reg;
   assign E_MDUOut = (E_MDUOp == 4'd5) ? hi_reg :
                     (E_MDUOp == 4'd6) ? lo_reg : 32'd0;

   // One 64-bit multiplier serves both flavours: sign-extending the operands
   // makes the low 64 bits of the product correct for signed mult too.
   always_comb begin
      mul_a   = {{32{is_signed & E_A[31]}}, E_A};
      mul_b   = {{32{is_signed & E_B[31]}}, E_B};
      product = mul_a * mul_b;

      neg_a = is_signed & E_A[31];
      neg_b = is_signed & E_B[31];
      mag_a = neg_a ? (~E_A + 32'd1) : E_A;
      mag_b = neg_b ? (~E_B + 32'd1) : E_B;
      uquo  = mag_a / mag_b;
      urem  = mag_a % mag_b;
      quo   = (neg_a ^ neg_b) ? (~uquo + 32'd1) : uquo;
      rem   = neg_a ? (~urem + 32'd1) : urem;

      res_hi = product[63:32];
      res_lo = product[31:0];
      if (is_div) begin
         if (div_zero) begin
            res_hi = E_A;
            res_lo = 32'hFFFF_FFFF;
         end else begin
            res_hi = rem;
            res_lo = quo;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= S_IDLE;
         cnt_reg     <= '0;
         hi_reg      <= 32'd0;
         lo_reg      <= 32'd0;
         pend_hi_reg <= 32'd0;
         pend_lo_reg <= 32'd0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  pend_hi_reg <= res_hi;
                  pend_lo_reg <= res_lo;
                  cnt_reg     <= is_div ? DIV_LOAD : MULT_LOAD;
                  state_reg   <= S_BUSY;
               end else if (E_MDUOp == 4'd7) begin
                  hi_reg <= E_A;
               end else if (E_MDUOp == 4'd8) begin
                  lo_reg <= E_A;
               end
            end
            S_BUSY: begin
               // Any op arriving here is ignored; md_stall should have held it in D.
               if (cnt_reg == '0) begin
                  hi_reg    <= pend_hi_reg;
                  lo_reg    <= pend_lo_reg;
                  state_reg <= S_IDLE;
               end else begin
                  cnt_reg <= cnt_reg - CNT_W'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed test-plan cases plus randomized traffic
// compared every cycle against a timestamp-based behavioural model.
module tb_mdu_ctrl;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  E_MDUOp;
   logic [31:0] E_A, E_B;
   logic        D_is_md;
   logic        start, busy, md_stall;
   logic [31:0] E_MDUOut, HI, LO;

   always #5 clk = ~clk;

   mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .E_MDUOp(E_MDUOp), .E_A(E_A), .E_B(E_B),
      .D_is_md(D_is_md), .start(start), .busy(busy), .md_stall(md_stall),
      .E_MDUOut(E_MDUOut), .HI(HI), .LO(LO)
   );

   int n_cmp = 0;
   int n_bad = 0;
   bit cmp_en = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: results computed with plain 64-bit arithmetic,
   // busy tracked as "pending until cycle m_done".
   int unsigned cyc    = 0;
   int unsigned m_done = 0;
   bit          m_pend = 0;
   logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;

   function automatic bit starts(input logic [3:0] op, input logic [31:0] b);
      if (op < 4'd1 || op > 4'd4) return 1'b0;
`ifdef MDU_DIVZERO_GUARD_EN
      if (op >= 4'd3 && b == 32'd0) return 1'b0;
`endif
      return 1'b1;
   endfunction

   function automatic logic [63:0] mdu_result(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] ua, ub;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         4'd1: return sa * sb;
         4'd2: return ua * ub;
         default: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (op == 4'd3) begin
               q = sa / sb;
               r = sa % sb;
               return {r[31:0], q[31:0]};
            end
            return {(ua % ub) & 64'hFFFF_FFFF, (ua / ub) & 64'hFFFF_FFFF} & 64'hFFFF_FFFF_FFFF_FFFF
                   ? {32'(ua % ub), 32'(ua / ub)} : {32'(ua % ub), 32'(ua / ub)};
         end
      endcase
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_pend <= 1'b0;
         m_hi   <= 32'd0;
         m_lo   <= 32'd0;
         m_phi  <= 32'd0;
         m_plo  <= 32'd0;
      end else begin
         if (m_pend) begin
            if (cyc == m_done) begin
               m_hi   <= m_phi;
               m_lo   <= m_plo;
               m_pend <= 1'b0;
            end
         end else if (starts(E_MDUOp, E_B)) begin
            {m_phi, m_plo} <= mdu_result(E_MDUOp, E_A, E_B);
            m_pend <= 1'b1;
            m_done <= cyc + ((E_MDUOp <= 4'd2) ? MC : DC);
         end else if (E_MDUOp == 4'd7) begin
            m_hi <= E_A;
         end else if (E_MDUOp == 4'd8) begin
            m_lo <= E_A;
         end
         cyc <= cyc + 1;
      end
   end

   wire        exp_start = !m_pend && starts(E_MDUOp, E_B);
   wire [31:0] exp_out   = (E_MDUOp == 4'd5) ? m_hi : (E_MDUOp == 4'd6) ? m_lo : 32'd0;

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("busy", busy, m_pend);
         chk("start", start, exp_start);
         chk("md_stall", md_stall, D_is_md & (exp_start | m_pend));
         chk("HI", HI, m_hi);
         chk("LO", LO, m_lo);
         chk("E_MDUOut", E_MDUOut, exp_out);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic dmd);
      E_MDUOp = op;
      E_A     = a;
      E_B     = b;
      D_is_md = dmd;
   endtask

   // Issue one op and return how many busy cycles followed; ends in the first idle cycle.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic dmd, output int nbusy);
      nbusy = 0;
      set_in(op, a, b, dmd);
      step();
      set_in(4'd0, 32'd0, 32'd0, dmd);
      for (int i = 0; i < 100; i++) begin
         #2;
         if (!busy) break;
         nbusy++;
         if (!dmd) chk("md_stall_no_md_in_D", md_stall, 1'b0);
         if (i == 99) chk("busy_timeout", 1'b1, 1'b0);
         step();
      end
   endtask

   int nb, nstall;

   initial begin
      reset = 1'b1;
      set_in(4'd0, 32'd0, 32'd0, 1'b0);
      step();
      step();
      chk("rst_busy", busy, 1'b0);
      chk("rst_HI", HI, 32'd0);
      chk("rst_LO", LO, 32'd0);
      chk("rst_start", start, 1'b0);
      chk("rst_md_stall", md_stall, 1'b0);
      chk("rst_E_MDUOut", E_MDUOut, 32'd0);
      reset = 1'b0;
      cmp_en = 1'b1;
      step();

      // Signed mult with a dependent mfhi held in D
      set_in(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b1);
      #2;
      chk("mult_start", start, 1'b1);
      nstall = md_stall ? 1 : 0;
      step();
      set_in(4'd0, 32'd0, 32'd0, 1'b1);
      for (int i = 0; i < 50; i++) begin
         #2;
         if (!md_stall) break;
         nstall++;
         if (i == 49) chk("stall_timeout", 1'b1, 1'b0);
         step();
      end
      chk("mfhi_stall_cycles", nstall, 6);
      step();
      set_in(4'd5, 32'd0, 32'd0, 1'b0);
      #2;
      chk("mfhi_after_mult", E_MDUOut, 32'hFFFF_FFFF);
      chk("mult_LO", LO, 32'hFFFF_FFFA);
      chk("model_pin_mult_hi", m_hi, 32'hFFFF_FFFF);
      step();

      // Signed and unsigned divide of -7 by 2
      run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, nb);
      chk("div_busy_cycles", nb, DC);
      chk("div_LO", LO, 32'hFFFF_FFFD);
      chk("div_HI", HI, 32'hFFFF_FFFF);
      chk("model_pin_div_lo", m_lo, 32'hFFFF_FFFD);
      run_op(4'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, nb);
      chk("divu_LO", LO, 32'h7FFF_FFFC);
      chk("divu_HI", HI, 32'd1);
      chk("model_pin_divu_hi", m_hi, 32'd1);

      // mthi then mfhi next cycle, mfhi waiting in D is not stalled
      set_in(4'd7, 32'h0000_1234, 32'd0, 1'b1);
      #2;
      chk("mthi_no_stall", md_stall, 1'b0);
      step();
      set_in(4'd5, 32'd0, 32'd0, 1'b0);
      #2;
      chk("mfhi_after_mthi", E_MDUOut, 32'h0000_1234);
      step();

      // Reset in the third busy cycle of a multu
      set_in(4'd2, 32'd7, 32'd9, 1'b0);
      step();
      set_in(4'd0, 32'd0, 32'd0, 1'b0);
      step();
      step();
      #2;
      chk("multu_busy_before_rst", busy, 1'b1);
      reset = 1'b1;
      #1;
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_HI", HI, 32'd0);
      chk("midrst_LO", LO, 32'd0);
      step();
      reset = 1'b0;
      for (int i = 0; i < 12; i++) step();
      chk("postrst_HI", HI, 32'd0);
      chk("postrst_LO", LO, 32'd0);

      // Divide by zero
      set_in(4'd3, 32'h55, 32'd0, 1'b1);
      #2;
`ifdef MDU_DIVZERO_GUARD_EN
      chk("divzero_start", start, 1'b0);
      chk("divzero_stall", md_stall, 1'b0);
`else
      chk("divzero_start", start, 1'b1);
`endif
      set_in(4'd0, 32'd0, 32'd0, 1'b0);
      run_op(4'd3, 32'h55, 32'd0, 1'b0, nb);
`ifdef MDU_DIVZERO_GUARD_EN
      chk("divzero_busy_cycles", nb, 0);
      chk("divzero_HI", HI, 32'd0);
      chk("divzero_LO", LO, 32'd0);
`else
      chk("divzero_busy_cycles", nb, DC);
      chk("divzero_HI", HI, 32'h55);
      chk("divzero_LO", LO, 32'hFFFF_FFFF);
`endif

      // Randomized traffic, checked each cycle by the compare process
      for (int i = 0; i < 1500; i++) begin
         logic [31:0] rb;
         case ($urandom_range(0, 7))
            0:       rb = 32'd0;
            1:       rb = $urandom_range(1, 9);
            2:       rb = 32'hFFFF_FFFF - $urandom_range(0, 9);
            default: rb = $urandom;
         endcase
         set_in(4'($urandom_range(0, 15)), $urandom, rb, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 249) == 0) begin
            #2;
            reset = 1'b1;
            step();
            reset = 1'b0;
         end else begin
            step();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
